// File: rtl/uart_baud_pkg.sv
// Shared state encoding and default parameters for the UART baud timebase.
// The auto-baud states exist only when UART_AUTOBAUD_EN is defined.
package uart_baud_pkg;

  localparam int                       SIZE_BAUD_DEF   = 24;
  localparam int                       OSR_DEF         = 16;
  localparam logic [SIZE_BAUD_DEF-1:0] DEFAULT_DIV_DEF = 24'd26;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_LOAD    = 3'd3
`ifdef UART_AUTOBAUD_EN
    ,
    ST_AB_ARM  = 3'd4,
    ST_AB_MEAS = 3'd5
`endif
  } baud_state_e;

endpackage

// File: rtl/uart_autobaud_meter.sv
// Auto-baud start-bit meter: synchronises the RX line, detects edges, measures
// the low width in clocks (saturating) and converts it to an oversample divisor.
module uart_autobaud_meter
  import uart_baud_pkg::*;
#(
  parameter int SIZE_BAUD = SIZE_BAUD_DEF,
  parameter int OSR       = OSR_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_arm,
  input  logic                 i_meas,
  output logic                 o_fall,
  output logic                 o_rise,
  output logic [SIZE_BAUD-1:0] o_div
);

  localparam int SHIFT = $clog2(OSR);

  logic [2:0]           rx_sh;
  logic                 rx_s;
  logic                 rx_d;
  logic [SIZE_BAUD-1:0] width_q;
  logic [SIZE_BAUD-1:0] quot;

  // rx_sh[1] is the synchronised line, rx_sh[2] its previous value for edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sh   <= 3'b111;
      width_q <= '0;
    end else begin
      rx_sh <= {rx_sh[1:0], i_rx};
      if (i_arm) begin
        width_q <= SIZE_BAUD'(1);
      end else if (i_meas && !rx_s && (width_q != '1)) begin
        width_q <= width_q + SIZE_BAUD'(1);
      end
    end
  end

  assign rx_s   = rx_sh[1];
  assign rx_d   = rx_sh[2];
  assign o_fall = rx_d && !rx_s;
  assign o_rise = !rx_d && rx_s;
  assign quot   = width_q >> SHIFT;
  assign o_div  = (quot == '0) ? '0 : quot - SIZE_BAUD'(1);

endmodule

// File: rtl/uart_baud_ctrl.sv
// UART baud timebase: oversample/bit tick generation with safe divisor reconfiguration.
// Auto-baud measurement is included when UART_AUTOBAUD_EN is defined.
//
// state    | meaning
// IDLE     | timebase stopped
// RUN      | counting, ticks at active divisor
// DRAIN    | divisor pending, ticking at old rate until TX and RX idle
// LOAD     | apply pending divisor, counters restart (1 cycle)
// AB_ARM   | auto-baud armed, waiting for start-bit falling edge
// AB_MEAS  | auto-baud measuring start-bit low width
module uart_baud_ctrl
  import uart_baud_pkg::*;
#(
  parameter int                   SIZE_BAUD   = SIZE_BAUD_DEF,
  parameter int                   OSR         = OSR_DEF,
  parameter logic [SIZE_BAUD-1:0] DEFAULT_DIV = SIZE_BAUD'(DEFAULT_DIV_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_cfg_valid,
  input  logic [SIZE_BAUD-1:0] i_cfg_div,
  output logic                 o_cfg_ready,
  input  logic                 i_tx_busy,
  input  logic                 i_rx_busy,
  output logic                 o_os_tick,
  output logic                 o_bit_tick,
  output logic [SIZE_BAUD-1:0] o_active_div,
  output logic                 o_pending,
  input  logic                 i_rx,
  input  logic                 i_ab_start,
  output logic                 o_ab_done
);

  localparam int             OSW     = $clog2(OSR);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);

  baud_state_e          state_q;
  baud_state_e          state_d;
  logic [SIZE_BAUD-1:0] cnt_q;
  logic [OSW-1:0]       os_idx_q;
  logic [SIZE_BAUD-1:0] active_div_q;
  logic [SIZE_BAUD-1:0] pend_div_q;
  logic                 pending_q;
  logic                 cfg_ready_q;
  logic                 ab_done_q;

  logic cfg_acc;
  logic bus_idle;
  logic apply_now;
  logic counting;
  logic os_tick;
  logic ab_load;

`ifdef UART_AUTOBAUD_EN
  logic                 ab_go;
  logic                 ab_fall;
  logic                 ab_rise;
  logic [SIZE_BAUD-1:0] ab_div;

  uart_autobaud_meter #(
    .SIZE_BAUD (SIZE_BAUD),
    .OSR       (OSR)
  ) u_meter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_rx   (i_rx),
    .i_arm  (state_q == ST_AB_ARM),
    .i_meas (state_q == ST_AB_MEAS),
    .o_fall (ab_fall),
    .o_rise (ab_rise),
    .o_div  (ab_div)
  );

  assign ab_go = i_ab_start && !pending_q;
`else
  logic unused_ab;
  assign unused_ab = i_rx ^ i_ab_start;
`endif

  assign cfg_acc   = i_cfg_valid && cfg_ready_q;
  assign bus_idle  = !i_tx_busy && !i_rx_busy;
  assign apply_now = !i_enable || bus_idle;
  assign counting  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign os_tick   = counting && (cnt_q == active_div_q);

  always_comb begin
    state_d = state_q;
    ab_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_acc)        state_d = apply_now ? ST_LOAD : ST_DRAIN;
        // a DRAIN interrupted by disable still owes its apply
        else if (pending_q) state_d = ST_LOAD;
`ifdef UART_AUTOBAUD_EN
        else if (ab_go)     state_d = ST_AB_ARM;
`endif
        else if (i_enable)  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cfg_acc)        state_d = apply_now ? ST_LOAD : ST_DRAIN;
`ifdef UART_AUTOBAUD_EN
        else if (ab_go)     state_d = ST_AB_ARM;
`endif
        else if (!i_enable) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (!i_enable)      state_d = ST_IDLE;
        else if (bus_idle)  state_d = ST_LOAD;
      end
      ST_LOAD: state_d = i_enable ? ST_RUN : ST_IDLE;
`ifdef UART_AUTOBAUD_EN
      ST_AB_ARM: begin
        if (ab_fall) state_d = ST_AB_MEAS;
      end
      ST_AB_MEAS: begin
        if (ab_rise) begin
          state_d = ST_LOAD;
          ab_load = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      os_idx_q     <= '0;
      active_div_q <= DEFAULT_DIV;
      pend_div_q   <= '0;
      pending_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
      ab_done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ab_done_q <= ab_load;

      if (counting && ((state_d == ST_RUN) || (state_d == ST_DRAIN))) begin
        if (os_tick) begin
          cnt_q    <= '0;
          os_idx_q <= os_idx_q + OSW'(1);
        end else begin
          cnt_q <= cnt_q + SIZE_BAUD'(1);
        end
      end else begin
        cnt_q    <= '0;
        os_idx_q <= '0;
      end

      if (cfg_acc) begin
        pend_div_q  <= i_cfg_div;
        pending_q   <= 1'b1;
        cfg_ready_q <= 1'b0;
      end
`ifdef UART_AUTOBAUD_EN
      if (ab_load) begin
        pend_div_q <= ab_div;
        pending_q  <= 1'b1;
      end
      if (state_d == ST_AB_ARM) cfg_ready_q <= 1'b0;
`endif
      if (state_q == ST_LOAD) begin
        active_div_q <= pend_div_q;
        pending_q    <= 1'b0;
        cfg_ready_q  <= 1'b1;
      end
    end
  end

  assign o_os_tick    = os_tick;
  assign o_bit_tick   = os_tick && (os_idx_q == OS_LAST);
  assign o_active_div = active_div_q;
  assign o_pending    = pending_q;
  assign o_cfg_ready  = cfg_ready_q;
  assign o_ab_done    = ab_done_q;

endmodule
